// File: rtl/sabinn_wb_regbank_if.sv
`default_nettype none
// ============================================================================
// Module   : sabinn_wb_regbank_if
// Purpose  : Wishbone classic slave bus bundle for the SABiNN register bank.
//            wbs_err_o exists only when SABINN_WB_ERR_EN is defined.
// Revision : 1.0
// ============================================================================
interface sabinn_wb_regbank_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
`ifdef SABINN_WB_ERR_EN
    logic        wbs_err_o;
`endif

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
`ifdef SABINN_WB_ERR_EN
        input  wbs_err_o,
`endif
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
`ifdef SABINN_WB_ERR_EN
        output wbs_err_o,
`endif
        output wbs_ack_o, wbs_dat_o
    );
endinterface
`default_nettype wire

// File: rtl/sabinn_wb_regbank.sv
`default_nettype none
// ============================================================================
// Module   : sabinn_wb_regbank
// Purpose  : Wishbone classic slave register bank with config registers,
//            IRQ enable/pending and wait-state FSM. Option: SABINN_WB_ERR_EN.
// Revision : 1.0
// ============================================================================
module sabinn_wb_regbank #(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter logic [31:0] ADDR_MASK   = 32'hFFFF_F000,
    parameter int          NREGS       = 8,
    parameter int          WAIT_STATES = 1,
    parameter int          IRQ_W       = 3
) (
    input  wire logic               wb_clk_i,
    input  wire logic               wb_rst_i,
    sabinn_wb_regbank_if.slave      bus,
    output logic [NREGS*32-1:0]     cfg_o,
    input  wire logic [IRQ_W-1:0]   irq_set_i,
    output logic [IRQ_W-1:0]        user_irq
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_ACK = 2'd2} state_t;

    localparam int         RIDX_W   = $clog2(NREGS);
    localparam logic [9:0] IDX_EN   = 10'(NREGS);
    localparam logic [9:0] IDX_PEND = 10'(NREGS + 1);

    state_t           state;
    logic [3:0]       cnt;
    logic [31:0]      regs [NREGS];
    logic [IRQ_W-1:0] irq_en;
    logic [IRQ_W-1:0] irq_pend;
    logic [9:0]       lat_idx;
    logic             lat_we;
    logic [3:0]       lat_sel;
    logic [31:0]      lat_dat;
    logic             ack;
    logic [31:0]      rdat;
`ifdef SABINN_WB_ERR_EN
    logic             err;
`endif

    logic             match;
    logic             req;
    logic             go_ack;
    logic             commit;
    logic [9:0]       rd_idx;
    logic [31:0]      rd_val;
    logic [31:0]      bmask;
    logic [31:0]      wdat;
    logic [IRQ_W-1:0] clr;

    assign match  = (bus.wbs_adr_i & ADDR_MASK) == (BASE_ADDR & ADDR_MASK);
    assign req    = bus.wbs_cyc_i & bus.wbs_stb_i & match & ~ack;
    assign go_ack = (state == S_IDLE && req && WAIT_STATES == 0) ||
                    (state == S_WAIT && bus.wbs_cyc_i && cnt == 4'd0);
    assign commit = (state == S_ACK) && lat_we;
    // With zero wait states the read happens on the acceptance edge, before the latch is loaded.
    assign rd_idx = (state == S_IDLE) ? bus.wbs_adr_i[11:2] : lat_idx;

    for (genvar k = 0; k < 4; k++) begin : g_lane
        assign bmask[8*k +: 8] = {8{lat_sel[k]}};
    end

    assign wdat = lat_dat & bmask;
    assign clr  = (commit && lat_idx == IDX_PEND) ? wdat[IRQ_W-1:0] : '0;

    for (genvar gi = 0; gi < NREGS; gi++) begin : g_cfg
        assign cfg_o[32*gi +: 32] = regs[gi];
    end

    always_comb begin
        rd_val = '0;
        if (rd_idx < IDX_EN)
            rd_val = regs[rd_idx[RIDX_W-1:0]];
        else if (rd_idx == IDX_EN)
            rd_val[IRQ_W-1:0] = irq_en;
        else if (rd_idx == IDX_PEND)
            rd_val[IRQ_W-1:0] = irq_pend;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state    <= S_IDLE;
            cnt      <= 4'd0;
            ack      <= 1'b0;
            rdat     <= '0;
`ifdef SABINN_WB_ERR_EN
            err      <= 1'b0;
`endif
            irq_en   <= '0;
            irq_pend <= '0;
            user_irq <= '0;
            lat_idx  <= '0;
            lat_we   <= 1'b0;
            lat_sel  <= '0;
            lat_dat  <= '0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            ack      <= 1'b0;
            rdat     <= '0;
`ifdef SABINN_WB_ERR_EN
            err      <= 1'b0;
`endif
            user_irq <= irq_pend & irq_en;
            // A new set pulse overrides a simultaneous write-1-to-clear.
            irq_pend <= (irq_pend & ~clr) | irq_set_i;

            if (commit) begin
                for (int i = 0; i < NREGS; i++)
                    if (lat_idx == 10'(i)) regs[i] <= (regs[i] & ~bmask) | wdat;
                if (lat_idx == IDX_EN)
                    irq_en <= (irq_en & ~bmask[IRQ_W-1:0]) | wdat[IRQ_W-1:0];
            end

            if (go_ack) begin
`ifdef SABINN_WB_ERR_EN
                if (rd_idx > IDX_PEND) begin
                    err <= 1'b1;
                end else begin
                    ack  <= 1'b1;
                    rdat <= rd_val;
                end
`else
                ack  <= 1'b1;
                rdat <= rd_val;
`endif
            end

            case (state)
                S_IDLE: begin
                    if (req) begin
                        lat_idx <= bus.wbs_adr_i[11:2];
                        lat_we  <= bus.wbs_we_i;
                        lat_sel <= bus.wbs_sel_i;
                        lat_dat <= bus.wbs_dat_i;
                        if (WAIT_STATES == 0) begin
                            state <= S_ACK;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= 4'(WAIT_STATES - 1);
                        end
                    end
                end
                S_WAIT: begin
                    if (!bus.wbs_cyc_i)
                        state <= S_IDLE;
                    else if (cnt == 4'd0)
                        state <= S_ACK;
                    else
                        cnt <= cnt - 4'd1;
                end
                S_ACK:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.wbs_ack_o = ack;
    assign bus.wbs_dat_o = rdat;
`ifdef SABINN_WB_ERR_EN
    assign bus.wbs_err_o = err;
`endif
endmodule
`default_nettype wire

// File: tb/tb_sabinn_wb_regbank.sv
`default_nettype none
// ============================================================================
// Module   : tb_sabinn_wb_regbank
// Purpose  : Self-checking bench for sabinn_wb_regbank: directed register and
//            IRQ scenarios plus randomized traffic against a transaction model.
// Revision : 1.0
// ============================================================================
module tb_sabinn_wb_regbank;
    localparam int          NREGS = 8;
    localparam int          IRQ_W = 3;
    localparam int          WS    = 1;
    localparam logic [31:0] BASE  = 32'h3000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sabinn_wb_regbank_if bus ();
    sabinn_wb_regbank_if bus3 ();
    logic [NREGS*32-1:0] cfg, cfg3;
    logic [IRQ_W-1:0]    irq_set  = '0;
    logic [IRQ_W-1:0]    irq_set3 = '0;
    logic [IRQ_W-1:0]    uirq, uirq3;

    sabinn_wb_regbank #(.NREGS(NREGS), .WAIT_STATES(WS), .IRQ_W(IRQ_W)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .bus(bus.slave),
        .cfg_o(cfg), .irq_set_i(irq_set), .user_irq(uirq));

    sabinn_wb_regbank #(.NREGS(NREGS), .WAIT_STATES(3), .IRQ_W(IRQ_W)) dut3 (
        .wb_clk_i(clk), .wb_rst_i(rst), .bus(bus3.slave),
        .cfg_o(cfg3), .irq_set_i(irq_set3), .user_irq(uirq3));

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp_v, $time);
        end
    endtask

    function automatic bit in_window(input logic [31:0] a);
        return (a & 32'hFFFF_F000) == BASE;
    endfunction

    function automatic logic [31:0] lanes(input logic [3:0] s);
        logic [31:0] m;
        for (int k = 0; k < 4; k++) m[8*k +: 8] = {8{s[k]}};
        return m;
    endfunction

    // Transaction-level reference: register file, IRQ state, and a countdown to the ack.
    logic [31:0]      m_cfg [NREGS];
    logic [IRQ_W-1:0] m_en, m_pend, m_uirq;
    bit               m_ack, m_busy, m_on;
    int               m_wait;
    logic [31:0]      m_rd;
    int               t_idx;
    bit               t_we;
    logic [3:0]       t_sel;
    logic [31:0]      t_dat;

    function automatic logic [31:0] m_read(input int idx);
        if (idx < NREGS)     return m_cfg[idx];
        if (idx == NREGS)    return 32'(m_en);
        if (idx == NREGS + 1) return 32'(m_pend);
        return 32'h0;
    endfunction

    always @(posedge clk) begin : model
        logic [IRQ_W-1:0] clr, nxt_uirq;
        logic [31:0]      wm;
        bit               nxt_ack;
        if (rst) begin
            for (int i = 0; i < NREGS; i++) m_cfg[i] = '0;
            m_en = '0; m_pend = '0; m_uirq = '0;
            m_ack = 0; m_busy = 0; m_rd = '0; m_on = 1;
        end else begin
            clr      = '0;
            nxt_ack  = 0;
            nxt_uirq = m_pend & m_en;
            if (m_ack && t_we) begin
                wm = lanes(t_sel);
                if (t_idx < NREGS)
                    m_cfg[t_idx] = (m_cfg[t_idx] & ~wm) | (t_dat & wm);
                else if (t_idx == NREGS)
                    m_en = (m_en & ~wm[IRQ_W-1:0]) | (t_dat[IRQ_W-1:0] & wm[IRQ_W-1:0]);
                else if (t_idx == NREGS + 1)
                    clr = t_dat[IRQ_W-1:0] & wm[IRQ_W-1:0];
            end
            if (m_busy) begin
                if (!bus.wbs_cyc_i) begin
                    m_busy = 0;
                end else begin
                    m_wait--;
                    if (m_wait == 0) begin
                        m_busy  = 0;
                        nxt_ack = 1;
                    end
                end
            end else if (!m_ack && bus.wbs_cyc_i && bus.wbs_stb_i && in_window(bus.wbs_adr_i)) begin
                t_idx = int'(bus.wbs_adr_i[11:2]);
                t_we  = bus.wbs_we_i;
                t_sel = bus.wbs_sel_i;
                t_dat = bus.wbs_dat_i;
                m_busy = 1;
                m_wait = WS;
            end
            m_rd   = nxt_ack ? m_read(t_idx) : 32'h0;
            m_pend = (m_pend & ~clr) | irq_set;
            m_uirq = nxt_uirq;
            m_ack  = nxt_ack;
        end
    end

    always @(negedge clk) begin : compare
        logic [NREGS*32-1:0] flat;
        if (m_on) begin
            for (int i = 0; i < NREGS; i++) flat[32*i +: 32] = m_cfg[i];
            chk("ack", 256'(bus.wbs_ack_o), 256'(m_ack));
            if (!m_ack || !t_we) chk("rdata", 256'(bus.wbs_dat_o), 256'(m_rd));
            chk("cfg", 256'(cfg), 256'(flat));
            chk("user_irq", 256'(uirq), 256'(m_uirq));
        end
    end

    bit rand_irq = 0;
    bit set_on_commit = 0;

    task automatic drive(input bit use3, input bit cyc, input bit we, input logic [3:0] sel,
                         input logic [31:0] adr, input logic [31:0] dat);
        if (use3) begin
            bus3.wbs_cyc_i = cyc; bus3.wbs_stb_i = cyc; bus3.wbs_we_i = we;
            bus3.wbs_sel_i = sel; bus3.wbs_adr_i = adr; bus3.wbs_dat_i = dat;
        end else begin
            bus.wbs_cyc_i = cyc; bus.wbs_stb_i = cyc; bus.wbs_we_i = we;
            bus.wbs_sel_i = sel; bus.wbs_adr_i = adr; bus.wbs_dat_i = dat;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        irq_set = (rand_irq && $urandom_range(0, 3) == 0) ? IRQ_W'($urandom) : '0;
    endtask

    // Entered and left 1 time unit after a rising edge; abort_at drops cyc after that many edges.
    task automatic access(input bit use3, input logic [31:0] adr, input bit we, input logic [3:0] sel,
                          input logic [31:0] dat, input int limit, input int abort_at,
                          output bit acked, output logic [31:0] rdata, output int lat);
        acked = 0; rdata = '0; lat = -1;
        drive(use3, 1, we, sel, adr, dat);
        for (int n = 0; n < limit && !acked; n++) begin
            if (n == abort_at) drive(use3, 0, 0, 4'h0, 32'h0, 32'h0);
            @(negedge clk);
            if (use3 ? bus3.wbs_ack_o : bus.wbs_ack_o) begin
                acked = 1;
                rdata = use3 ? bus3.wbs_dat_o : bus.wbs_dat_o;
                lat   = n;
                if (set_on_commit) irq_set = 3'b001;
            end
            tick();
        end
        drive(use3, 0, 0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic wr(input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat);
        bit a; logic [31:0] r; int l;
        access(0, adr, 1, sel, dat, 20, -1, a, r, l);
        chk("wr_acked", 256'(a), 256'(1));
    endtask

    task automatic rd(input logic [31:0] adr, output logic [31:0] r);
        bit a; int l;
        access(0, adr, 0, 4'hF, 32'h0, 20, -1, a, r, l);
        chk("rd_acked", 256'(a), 256'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [31:0] r, adr;
        bit          a;
        int          l, kind, idx;
        drive(0, 0, 0, 4'h0, 32'h0, 32'h0);
        drive(1, 0, 0, 4'h0, 32'h0, 32'h0);
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack", 256'(bus.wbs_ack_o), 256'(0));
        chk("rst_cfg", 256'(cfg), 256'(0));
        chk("rst_uirq", 256'(uirq), 256'(0));
        rst = 0;

        access(0, BASE + 32'hC, 1, 4'hF, 32'hDEAD_BEEF, 20, -1, a, r, l);
        chk("wr3_acked", 256'(a), 256'(1));
        chk("wr3_latency", 256'(l), 256'(2));
        chk("cfg_reg3", 256'(cfg[127:96]), 256'(32'hDEAD_BEEF));
        rd(BASE + 32'hC, r);
        chk("rd_reg3", 256'(r), 256'(32'hDEAD_BEEF));
        wr(BASE + 32'hC, 4'b0101, 32'h1122_3344);
        rd(BASE + 32'hC, r);
        chk("byte_enable", 256'(r), 256'(32'hDE22_BE44));

        access(0, BASE + 32'h100C, 1, 4'hF, 32'h0, 20, -1, a, r, l);
        chk("oow_noack", 256'(a), 256'(0));
        rd(BASE + 32'hC, r);
        chk("oow_unchanged", 256'(r), 256'(32'hDE22_BE44));

        wr(BASE + 32'h20, 4'hF, 32'h5);
        irq_set = 3'b111;
        repeat (3) tick();
        rd(BASE + 32'h24, r);
        chk("pend_all", 256'(r), 256'(32'h7));
        chk("uirq_101", 256'(uirq), 256'(3'b101));
        set_on_commit = 1;
        wr(BASE + 32'h24, 4'hF, 32'h1);
        set_on_commit = 0;
        rd(BASE + 32'h24, r);
        chk("set_wins", 256'(r), 256'(32'h7));
        wr(BASE + 32'h24, 4'hF, 32'h1);
        repeat (2) tick();
        chk("uirq_100", 256'(uirq), 256'(3'b100));
        rd(BASE + 32'h24, r);
        chk("pend_cleared", 256'(r), 256'(32'h6));

        drive(0, 1, 1, 4'hF, BASE + 32'h4, 32'hFFFF_FFFF);
        tick();
        rst = 1;
        drive(0, 0, 0, 4'h0, 32'h0, 32'h0);
        tick();
        rst = 0;
        a = 0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (bus.wbs_ack_o) a = 1;
            tick();
        end
        chk("rst_mid_noack", 256'(a), 256'(0));
        chk("rst_mid_cfg", 256'(cfg), 256'(0));
        chk("rst_mid_uirq", 256'(uirq), 256'(0));

        access(1, BASE + 32'h8, 1, 4'hF, 32'h55AA_55AA, 20, -1, a, r, l);
        chk("ws3_acked", 256'(a), 256'(1));
        chk("ws3_latency", 256'(l), 256'(4));
        access(1, BASE + 32'h8, 1, 4'hF, 32'h1234_5678, 12, 2, a, r, l);
        chk("abort_noack", 256'(a), 256'(0));
        chk("abort_cfg", 256'(cfg3[95:64]), 256'(32'h55AA_55AA));
        access(1, BASE + 32'h8, 0, 4'hF, 32'h0, 20, -1, a, r, l);
        chk("post_abort_acked", 256'(a), 256'(1));
        chk("post_abort_rd", 256'(r), 256'(32'h55AA_55AA));

        rand_irq = 1;
        for (int t = 0; t < 400; t++) begin
            kind = $urandom_range(0, 15);
            idx  = $urandom_range(0, NREGS + 3);
            if (kind == 0) begin
                adr = $urandom;
                if (in_window(adr)) adr = adr ^ 32'h0000_1000;
                access(0, adr, 1'($urandom), 4'($urandom), $urandom, 3, -1, a, r, l);
            end else begin
                adr = BASE + 32'(idx * 4) + 32'($urandom_range(0, 3));
                access(0, adr, 1'($urandom), 4'($urandom), $urandom,
                       (kind == 1) ? 6 : 20, (kind == 1) ? 1 : -1, a, r, l);
            end
            repeat ($urandom_range(0, 2)) tick();
        end
        rand_irq = 0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
